// File: rtl/knn_loader.sv
// Streaming loader for the KNN query and reference memories: assembles LSB-first byte beats into records.
// Optional class-range check on reference records is enabled by defining KNN_CLASS_CHECK_EN.
module knn_loader #(
  parameter int DATA_DIM          = 2,
  parameter int DIM_PREC          = 4,
  parameter int CLASSIFICATIONS   = 3,
  parameter int QUERY_DATA_POINTS = 2,
  parameter int REF_DATA_POINTS   = 4,
  parameter int IN_W              = 8,
  localparam int CW  = $clog2(CLASSIFICATIONS),
  localparam int QW  = DATA_DIM * DIM_PREC,
  localparam int RW  = CW + QW,
  localparam int QAW = $clog2(QUERY_DATA_POINTS),
  localparam int RAW = $clog2(REF_DATA_POINTS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [IN_W-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            q_we,
  output logic [QAW-1:0]  q_addr,
  output logic [QW-1:0]   q_wdata,
  output logic            r_we,
  output logic [RAW-1:0]  r_addr,
  output logic [RW-1:0]   r_wdata,
  output logic            load_done,
  output logic            err,
  output logic [1:0]      fsm_state
);

  localparam int QB  = (QW + IN_W - 1) / IN_W;
  localparam int RB  = (RW + IN_W - 1) / IN_W;
  localparam int AW  = ((RB > QB) ? RB : QB) * IN_W;
  localparam int MB  = (RB > QB) ? RB : QB;
  localparam int BCW = (MB > 1) ? $clog2(MB) : 1;
  localparam int RCW = (QAW > RAW) ? QAW : RAW;

  localparam logic [BCW-1:0] QB_LAST = BCW'(QB - 1);
  localparam logic [BCW-1:0] RB_LAST = BCW'(RB - 1);
  localparam logic [RCW-1:0] Q_LAST  = RCW'(QUERY_DATA_POINTS - 1);
  localparam logic [RCW-1:0] R_LAST  = RCW'(REF_DATA_POINTS - 1);

  typedef enum logic [1:0] {IDLE, Q_LOAD, R_LOAD, DONE} state_t;

  state_t         state, state_next;
  logic [BCW-1:0] bcnt;
  logic [RCW-1:0] rec;
  logic [AW-1:0]  asm_reg, asm_next;
  logic           accept, rec_end, class_bad, clear;

  // Handshake: a beat transfers on any rising edge where in_valid && in_ready;
  // in_ready depends only on the FSM state, never on in_valid.
  assign in_ready  = (state == Q_LOAD) || (state == R_LOAD);
  assign load_done = (state == DONE);
  assign fsm_state = state;
  assign accept    = in_valid && in_ready;
  assign rec_end   = (bcnt == ((state == Q_LOAD) ? QB_LAST : RB_LAST));

  always_comb begin
    asm_next = asm_reg;
    asm_next[bcnt*IN_W +: IN_W] = in_data;
  end

`ifdef KNN_CLASS_CHECK_EN
  localparam logic [CW:0] CLS_LIM = (CW+1)'(CLASSIFICATIONS);
  assign class_bad = (state == R_LOAD) && rec_end && ({1'b0, asm_next[RW-1:QW]} >= CLS_LIM);
`else
  assign class_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    clear      = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_next = Q_LOAD;
        clear      = 1'b1;
      end
      Q_LOAD: if (accept && rec_end && rec == Q_LAST) state_next = R_LOAD;
      R_LOAD: if (accept && rec_end && !class_bad && rec == R_LAST) state_next = DONE;
      DONE: if (start) begin
        state_next = Q_LOAD;
        clear      = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // Assembly and write-data registers are separate so a record can assemble while the previous one writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bcnt    <= '0;
      rec     <= '0;
      asm_reg <= '0;
      q_we    <= 1'b0;
      q_addr  <= '0;
      q_wdata <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      q_we <= 1'b0;
      r_we <= 1'b0;
      if (clear) begin
        bcnt <= '0;
        rec  <= '0;
      end else if (accept) begin
        asm_reg <= asm_next;
        if (!rec_end) begin
          bcnt <= bcnt + 1'b1;
        end else begin
          bcnt <= '0;
          if (state == Q_LOAD) begin
            q_we    <= 1'b1;
            q_addr  <= rec[QAW-1:0];
            q_wdata <= asm_next[QW-1:0];
            rec     <= (rec == Q_LAST) ? '0 : rec + 1'b1;
          end else if (!class_bad) begin
            r_we    <= 1'b1;
            r_addr  <= rec[RAW-1:0];
            r_wdata <= asm_next[RW-1:0];
            rec     <= (rec == R_LAST) ? '0 : rec + 1'b1;
          end
        end
      end
    end
  end

`ifdef KNN_CLASS_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                    err <= 1'b0;
    else if (clear)                err <= 1'b0;
    else if (accept && class_bad)  err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule
